// File: rtl/win3x3_linebuf.sv
// rtl/win3x3_linebuf.sv - raster 3x3 window generator, edge replication (WIN_ZERO_PAD_EN: zero padding)
module win3x3_linebuf #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int DW    = 8,
  parameter int CW    = 19
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            Start_sig,
  input  logic [DW-1:0]   Pix_in,
  input  logic            Pix_valid,
  output logic            Pix_ready,
  output logic [9*DW-1:0] Win_data,
  output logic            Win_valid,
  output logic [CW-1:0]   Win_cy,
  output logic            Done_sig
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);
  localparam logic [CW-1:0] N_LAST    = CW'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(IMG_W);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   in_cnt;
  logic [CW-1:0]   out_cnt;
  logic [XW-1:0]   in_col;
  logic [XW-1:0]   cen_col;
  logic [YW-1:0]   cen_row;
  logic            done_arm;

  logic [DW-1:0]   lb_a [IMG_W];
  logic [DW-1:0]   lb_b [IMG_W];
  logic [DW-1:0]   hist1 [3];
  logic [DW-1:0]   hist2 [3];
  logic [DW-1:0]   col_new [3];
  logic [9*DW-1:0] win_nxt;

  logic            accept;
  logic            flush_step;
  logic            step;
  logic            emit;
  logic [1:0]      sel_r;
  logic [1:0]      sel_c;
  logic [DW-1:0]   tap_px;

  assign accept     = Start_sig && Pix_valid && Pix_ready &&
                      (state == S_FILL || state == S_RUN);
  assign flush_step = Start_sig && (state == S_FLUSH);
  assign step       = accept || flush_step;
  assign emit       = step && (state == S_RUN || state == S_FLUSH);

  // Newest column: rows cy+1, cy, cy-1 of the window, i.e. stream delays 0, W, 2W.
  assign col_new[2] = (state == S_FLUSH) ? '0 : Pix_in;
  assign col_new[1] = lb_a[in_col];
  assign col_new[0] = lb_b[in_col];

  always_ff @(posedge CLK) begin
    if (step) begin
      lb_b[in_col] <= lb_a[in_col];
      lb_a[in_col] <= col_new[2];
    end
  end

  // Out-of-image taps are redirected to the centre row/column, so stream wrap never leaks in.
  always_comb begin
    win_nxt = '0;
    sel_r   = 2'd0;
    sel_c   = 2'd0;
    tap_px  = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        sel_r = 2'(r);
        sel_c = 2'(c);
        if (r == 0 && cen_row == '0)    sel_r = 2'd1;
        if (r == 2 && cen_row == Y_LAST) sel_r = 2'd1;
        if (c == 0 && cen_col == '0)    sel_c = 2'd1;
        if (c == 2 && cen_col == X_LAST) sel_c = 2'd1;
        case (sel_c)
          2'd0:    tap_px = hist2[sel_r];
          2'd1:    tap_px = hist1[sel_r];
          default: tap_px = col_new[sel_r];
        endcase
`ifdef WIN_ZERO_PAD_EN
        if (sel_r != 2'(r) || sel_c != 2'(c)) tap_px = '0;
`endif
        win_nxt[(r*3+c)*DW +: DW] = tap_px;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      Pix_ready <= 1'b0;
      Win_valid <= 1'b0;
      Win_data  <= '0;
      Win_cy    <= '0;
      Done_sig  <= 1'b0;
      done_arm  <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      in_col    <= '0;
      cen_col   <= '0;
      cen_row   <= '0;
      for (int i = 0; i < 3; i++) begin
        hist1[i] <= '0;
        hist2[i] <= '0;
      end
    end else begin
      Win_valid <= 1'b0;
      Done_sig  <= done_arm;
      done_arm  <= 1'b0;
      case (state)
        S_IDLE: begin
          in_cnt  <= '0;
          out_cnt <= '0;
          in_col  <= '0;
          cen_col <= '0;
          cen_row <= '0;
          if (Start_sig) begin
            state     <= S_FILL;
            Pix_ready <= 1'b1;
          end
        end
        S_FILL, S_RUN, S_FLUSH: begin
          if (!Start_sig) begin
            state     <= S_IDLE;
            Pix_ready <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            in_col    <= '0;
            cen_col   <= '0;
            cen_row   <= '0;
          end else if (step) begin
            in_col <= (in_col == X_LAST) ? '0 : in_col + XW'(1);
            for (int i = 0; i < 3; i++) begin
              hist2[i] <= hist1[i];
              hist1[i] <= col_new[i];
            end
            if (accept) in_cnt <= in_cnt + CW'(1);
            if (state == S_FILL && in_cnt == FILL_LAST) state <= S_RUN;
            if (state == S_RUN && in_cnt == N_LAST) begin
              state     <= S_FLUSH;
              Pix_ready <= 1'b0;
            end
            if (emit) begin
              Win_valid <= 1'b1;
              Win_data  <= win_nxt;
              Win_cy    <= out_cnt;
              out_cnt   <= out_cnt + CW'(1);
              if (cen_col == X_LAST) begin
                cen_col <= '0;
                cen_row <= cen_row + YW'(1);
              end else begin
                cen_col <= cen_col + XW'(1);
              end
            end
            if (state == S_FLUSH && out_cnt == N_LAST) begin
              state    <= S_DONE;
              done_arm <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!Start_sig) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
